// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and FSM state encoding for the
// execute-stage ALU with iterative multiply/divide.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_SLT   = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_NOR   = 5'h04;
    localparam logic [4:0] OP_OR    = 5'h05;
    localparam logic [4:0] OP_XOR   = 5'h06;
    localparam logic [4:0] OP_SLL   = 5'h07;
    localparam logic [4:0] OP_SRL   = 5'h08;
    localparam logic [4:0] OP_SLTU  = 5'h09;
    localparam logic [4:0] OP_SLLV  = 5'h0C;
    localparam logic [4:0] OP_SRA   = 5'h0D;
    localparam logic [4:0] OP_SRAV  = 5'h0E;
    localparam logic [4:0] OP_SRLV  = 5'h0F;
    localparam logic [4:0] OP_LUI   = 5'h10;
    localparam logic [4:0] OP_MULT  = 5'h11;
    localparam logic [4:0] OP_MULTU = 5'h12;
    localparam logic [4:0] OP_DIV   = 5'h13;
    localparam logic [4:0] OP_DIVU  = 5'h14;
    localparam logic [4:0] OP_MFHI  = 5'h15;
    localparam logic [4:0] OP_MFLO  = 5'h16;
    localparam logic [4:0] OP_MTHI  = 5'h17;
    localparam logic [4:0] OP_MTLO  = 5'h18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 shift-add multiplier / restoring divider.
// Ports: i_start/i_abort control, i_is_div/i_is_signed mode,
// i_a/i_b operands, o_busy, o_done (last step this cycle),
// o_hi_out/o_lo_out sign-corrected results (valid after done).
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_is_div,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi_out,
    output logic [WIDTH-1:0] o_lo_out
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_bzero;
    logic [WIDTH-1:0] r_a_orig;
    // r_acc: product high half / partial remainder
    // r_b:   multiplicand / divisor magnitude
    // r_q:   multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;

    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_ma = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mb = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    assign w_sum  = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_b : '0)};
    assign w_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, r_b};
    // partial remainder stays below divisor, so a set top bit
    // of the difference means the trial subtraction borrowed
    assign w_ge   = ~w_diff[WIDTH];

    assign w_prod   = {r_acc, r_q};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_q : r_q;
    assign w_rem    = r_neg_r ? -r_acc : r_acc;

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);

    always_comb begin
        o_hi_out = w_prod_s[2*WIDTH-1:WIDTH];
        o_lo_out = w_prod_s[WIDTH-1:0];
        if (r_div) begin
            if (r_bzero) begin
                o_hi_out = r_a_orig;
                o_lo_out = '1;
            end else begin
                o_hi_out = w_rem;
                o_lo_out = w_quo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_a_orig <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_q      <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(WIDTH - 1);
            r_div    <= i_is_div;
            r_neg_q  <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_is_signed & i_a[WIDTH-1];
            r_bzero  <= (i_b == '0);
            r_a_orig <= i_a;
            r_acc    <= '0;
            r_b      <= w_mb;
            r_q      <= w_ma;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
            if (r_div) begin
                r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_ge};
            end else begin
                r_acc <= w_sum[WIDTH:1];
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU plus iterative MUL/DIV with HI/LO.
// Ports: clk, rst_n, in_valid/in_ready request handshake,
// alu_op/bus_a/bus_b/shamt operation, flush abort,
// out_valid pulse with result/zero, architectural hi/lo.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import alu_pkg::*;

    state_t           r_state;
    logic             r_valid;
    logic             r_zero;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_start;
    logic             w_busy;
    logic             w_last;
    logic [SHW-1:0]   w_sav;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_mhi;
    logic [WIDTH-1:0] w_mlo;

    // gated by rst_n so requesters see "not ready" during reset
    assign in_ready = rst_n && (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready && !flush;

    assign w_is_mul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
    assign w_is_div    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign w_is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign w_start     = w_accept && (w_is_mul || w_is_div);
    assign w_sav       = bus_a[SHW-1:0];

    assign out_valid = r_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign hi        = r_hi;
    assign lo        = r_lo;

    always_comb begin
        w_alu = '0;
        case (alu_op)
            OP_ADD:  w_alu = bus_a + bus_b;
            OP_SUB:  w_alu = bus_a - bus_b;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}},
                              $signed(bus_a) < $signed(bus_b)};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, bus_a < bus_b};
            OP_AND:  w_alu = bus_a & bus_b;
            OP_NOR:  w_alu = ~(bus_a | bus_b);
            OP_OR:   w_alu = bus_a | bus_b;
            OP_XOR:  w_alu = bus_a ^ bus_b;
            OP_SLL:  w_alu = bus_b << shamt;
            OP_SRL:  w_alu = bus_b >> shamt;
            OP_SRA:  w_alu = $signed(bus_b) >>> shamt;
            OP_SLLV: w_alu = bus_b << w_sav;
            OP_SRLV: w_alu = bus_b >> w_sav;
            OP_SRAV: w_alu = $signed(bus_b) >>> w_sav;
            OP_LUI:  w_alu = {bus_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: w_alu = r_hi;
            OP_MFLO: w_alu = r_lo;
            OP_MTHI: w_alu = bus_a;
            OP_MTLO: w_alu = bus_a;
            default: w_alu = '0;
        endcase
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_abort     (flush),
        .i_is_div    (w_is_div),
        .i_is_signed (w_is_signed),
        .i_a         (bus_a),
        .i_b         (bus_b),
        .o_busy      (w_busy),
        .o_done      (w_last),
        .o_hi_out    (w_mhi),
        .o_lo_out    (w_mlo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_zero   <= 1'b1;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else if (w_is_div) begin
                            r_state <= ST_DIV;
                        end else begin
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            if (alu_op == OP_MTHI) r_hi <= bus_a;
                            if (alu_op == OP_MTLO) r_lo <= bus_a;
                        end
                    end
                end
                // the !w_busy term only guards against a lost engine
                ST_MUL, ST_DIV: begin
                    if (w_last || !w_busy) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_state  <= ST_DONE;
                    r_valid  <= 1'b1;
                    r_hi     <= w_mhi;
                    r_lo     <= w_mlo;
                    r_result <= w_mlo;
                    r_zero   <= (w_mlo == '0);
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
